gpu_blitter: RTL and testbench
==============================

GPU_BLITTER -- requirements
Module: gpu_blitter

Interface
REQ-001 Parameter FB_WIDTH, default 400, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 240, framebuffer height in pixels.
REQ-003 Parameter FIFO_DEPTH, default 4, pixel return FIFO depth and max outstanding reads (power of two, >=2).
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command present; cmd_ready  output  1  command accepted when both high.
REQ-007 cmd_op  input  2  01 DRAW, 10 FILL, 11 CLEAR, 00 NOP.
REQ-008 cmd_address  input  32  source image base address.
REQ-009 cmd_src_x, cmd_src_y  input  16 each  source excerpt offset, unsigned.
REQ-010 cmd_image_width  input  16  source row pitch in pixels.
REQ-011 cmd_width, cmd_height  input  16 each  excerpt size, unsigned.
REQ-012 cmd_x, cmd_y  input  16 each  destination top-left, two's-complement signed.
REQ-013 cmd_color  input  16  FILL/CLEAR colour.
REQ-014 cmd_flip  input  2  bit0 horizontal, bit1 vertical mirror (DRAW only).
REQ-015 mem_read  output 1, mem_addr  output 32, mem_ready  input 1  read request, accepted when mem_read && mem_ready.
REQ-016 mem_valid  input 1, mem_data  input 16  in-order read return, any latency >=1.
REQ-017 fb_write  output 1, fb_x  output clog2(FB_WIDTH)+1, fb_y  output clog2(FB_HEIGHT)+1, fb_color  output 16, fb_ready  input 1  pixel write, taken when fb_write && fb_ready.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 States IDLE, DRAW, FILL; cmd_ready = (state == IDLE); NOP accepted, stays IDLE.
REQ-020 On accept all cmd_* latched; CLEAR latches x=y=0, width=FB_WIDTH, height=FB_HEIGHT, enters FILL; inputs ignored until IDLE.
REQ-021 width==0 or height==0: next cycle IDLE, no mem_read, no fb_write.
REQ-022 DRAW: request counter (col,row) raster order; mem_read asserted first cycle after accept; mem_addr = address + (src_y+r)*image_width + src_x + c, 32-bit wrap, c = flip[0] ? width-1-col : col, r = flip[1] ? height-1-row : row.
REQ-023 mem_read low when outstanding (issued minus popped) == FIFO_DEPTH; mem_addr held stable while mem_read && !mem_ready.
REQ-024 mem_valid pushes mem_data into FIFO; mem_valid with zero outstanding is discarded.
REQ-025 Output counter (ocol,orow) raster order, independent of request counter; dest = (x+ocol, y+orow) signed 17-bit.
REQ-026 Pixel with colour bit0==0 (transparent, DRAW only) or dest outside [0,FB_WIDTH)x[0,FB_HEIGHT): popped without fb_write, one per cycle.
REQ-027 Visible pixel: fb_write high with fb_x/fb_y/fb_color held until fb_ready; pop on handshake.
REQ-028 FILL: no memory traffic; fb_color = latched colour, transparency bit ignored, clipping per REQ-026, one pixel per cycle when fb_ready high.
REQ-029 Last output pixel consumed -> IDLE next cycle; busy low same cycle as cmd_ready high.
REQ-030 Throughput: one pixel per cycle sustained when mem latency < FIFO_DEPTH and fb_ready, mem_ready held high.

Reset
REQ-031 reset low: state IDLE, FIFO empty, outstanding 0, counters 0, mem_read 0, fb_write 0, busy 0, cmd_ready 1 after release; mid-command reset aborts with no further writes.

Configuration
REQ-032 GPU_BLIT_FLIP_EN defined: cmd_flip honoured per REQ-022; undefined: cmd_flip ignored, c=col, r=row, mirror logic absent.

Verification
REQ-033 DRAW 4x2, addr 0x1000, src (1,1), pitch 8, dest (10,20), latency 1 -> mem_addr 0x1009..0x100C,0x1011..0x1014; 8 fb_writes (10..13,20..21).
REQ-034 DRAW 4x1 dest x=-2, all opaque -> 4 reads, only fb_x 0,1 written.
REQ-035 CLEAR colour 0x0000 -> exactly 96000 fb_writes colour 0x0000, busy then low.
REQ-036 DRAW 8x1 latency 6, FIFO_DEPTH 4 -> outstanding never >4, pixel order preserved, fb_ready toggled each cycle without loss.
REQ-037 GPU_BLIT_FLIP_EN, flip=01, 4x1 addr 0 -> mem_addr 3,2,1,0 to fb_x 0..3; data 0x0002 at addr 1 -> fb_x 2 not written.
REQ-038 reset asserted mid-DRAW -> mem_read, fb_write 0 immediately; stale mem_valid ignored; next FILL 2x2 yields exactly 4 writes.

Source files
------------

// File: rtl/gpu_blitter.sv
// -----------------------------------------------------------------------------
// gpu_blitter
//   2D blitter. It copies a rectangular excerpt of a source image from memory
//   into the framebuffer (DRAW), or floods a rectangle with one colour
//   (FILL / CLEAR). Destination pixels outside the framebuffer are clipped.
//   DRAW pixels whose colour bit0 is 0 are transparent and are skipped.
//
//   Memory reads are issued by a request counter. Returned data lands in a
//   small FIFO. A separate output counter drains the FIFO. The number of reads
//   in flight (issued but not yet popped) never exceeds FIFO_DEPTH, so the
//   FIFO cannot overflow.
//
// Optional feature:
//   GPU_BLIT_FLIP_EN - when defined, cmd_flip mirrors the source horizontally
//                      (bit0) and/or vertically (bit1). When undefined, the
//                      mirror logic is absent and cmd_flip is ignored.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cmd_*                 command handshake and fields (accepted when idle)
//   mem_read/addr/ready   source read request
//   mem_valid/data        in-order read return
//   fb_write/x/y/color    framebuffer pixel write, taken on fb_ready
//   busy                  a command is in progress
// -----------------------------------------------------------------------------
module gpu_blitter #(
  parameter int FB_WIDTH   = 400,
  parameter int FB_HEIGHT  = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [31:0]                  cmd_address,
  input  logic [15:0]                  cmd_src_x,
  input  logic [15:0]                  cmd_src_y,
  input  logic [15:0]                  cmd_image_width,
  input  logic [15:0]                  cmd_width,
  input  logic [15:0]                  cmd_height,
  input  logic [15:0]                  cmd_x,
  input  logic [15:0]                  cmd_y,
  input  logic [15:0]                  cmd_color,
  input  logic [1:0]                   cmd_flip,
  output logic                         mem_read,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_ready,
  input  logic                         mem_valid,
  input  logic [15:0]                  mem_data,
  output logic                         fb_write,
  output logic [$clog2(FB_WIDTH):0]    fb_x,
  output logic [$clog2(FB_HEIGHT):0]   fb_y,
  output logic [15:0]                  fb_color,
  input  logic                         fb_ready,
  output logic                         busy
);

  localparam logic [1:0] OP_DRAW  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = $clog2(FB_WIDTH) + 1;
  localparam int YW = $clog2(FB_HEIGHT) + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [16:0]   FBW_C   = 17'(FB_WIDTH);
  localparam logic [16:0]   FBH_C   = 17'(FB_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  // Latched command fields
  logic [31:0] addr_r;
  logic [15:0] src_x_r;
  logic [15:0] src_y_r;
  logic [15:0] pitch_r;
  logic [15:0] w_r;
  logic [15:0] h_r;
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic [15:0] color_r;
`ifdef GPU_BLIT_FLIP_EN
  logic [1:0]  flip_r;
`else
  logic        unused_flip_s;
`endif

  // Request and output raster counters
  logic [15:0] rcol_r;
  logic [15:0] rrow_r;
  logic        req_done_r;
  logic [15:0] ocol_r;
  logic [15:0] orow_r;

  // Return FIFO and in-flight accounting
  logic [CW-1:0] out_cnt_r;
  logic [CW-1:0] fifo_cnt_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [15:0]   fifo_mem_r [FIFO_DEPTH];

  logic        accept_s;
  logic        zero_s;
  logic        req_fire_s;
  logic        req_last_s;
  logic        out_last_s;
  logic        pix_avail_s;
  logic        visible_s;
  logic        advance_s;
  logic        pop_s;
  logic        push_s;
  logic        in_x_s;
  logic        in_y_s;
  logic [15:0] pix_color_s;
  logic [15:0] c_s;
  logic [15:0] r_s;
  logic [16:0] dest_x_s;
  logic [16:0] dest_y_s;

`ifndef GPU_BLIT_FLIP_EN
  assign unused_flip_s = ^cmd_flip;
`endif

  assign cmd_ready  = (state_r == ST_IDLE);
  assign busy       = (state_r != ST_IDLE);
  assign accept_s   = cmd_valid && cmd_ready;
  // CLEAR always covers the full framebuffer, so it is never empty
  assign zero_s     = (cmd_op != OP_CLEAR) &&
                      ((cmd_width == 16'd0) || (cmd_height == 16'd0));

  assign mem_read   = (state_r == ST_DRAW) && !req_done_r && (out_cnt_r != DEPTH_C);
  assign req_fire_s = mem_read && mem_ready;
  assign req_last_s = (rcol_r == (w_r - 16'd1)) && (rrow_r == (h_r - 16'd1));
  assign out_last_s = (ocol_r == (w_r - 16'd1)) && (orow_r == (h_r - 16'd1));

  // Source column/row, optionally mirrored within the excerpt
  always_comb begin
    c_s = rcol_r;
    r_s = rrow_r;
`ifdef GPU_BLIT_FLIP_EN
    if (flip_r[0]) begin
      c_s = w_r - 16'd1 - rcol_r;
    end else begin
      c_s = rcol_r;
    end
    if (flip_r[1]) begin
      r_s = h_r - 16'd1 - rrow_r;
    end else begin
      r_s = rrow_r;
    end
`endif
  end

  // Address depends only on registers, so it stays put while a request stalls
  assign mem_addr = addr_r + ((32'(src_y_r) + 32'(r_s)) * 32'(pitch_r))
                  + 32'(src_x_r) + 32'(c_s);

  // Signed destination: sign-extend the 16-bit origin, add the unsigned offset
  assign dest_x_s = {x_r[15], x_r} + {1'b0, ocol_r};
  assign dest_y_s = {y_r[15], y_r} + {1'b0, orow_r};
  assign in_x_s   = !dest_x_s[16] && (dest_x_s < FBW_C);
  assign in_y_s   = !dest_y_s[16] && (dest_y_s < FBH_C);

  // Current output pixel: FIFO head in DRAW, latched colour in FILL
  always_comb begin
    pix_avail_s = 1'b0;
    pix_color_s = color_r;
    if (state_r == ST_DRAW) begin
      pix_avail_s = (fifo_cnt_r != {CW{1'b0}});
      pix_color_s = fifo_mem_r[rd_ptr_r];
    end else if (state_r == ST_FILL) begin
      pix_avail_s = 1'b1;
      pix_color_s = color_r;
    end else begin
      pix_avail_s = 1'b0;
      pix_color_s = color_r;
    end
  end

  // Transparency only applies to DRAW; clipping applies to both
  assign visible_s = in_x_s && in_y_s && ((state_r == ST_FILL) || pix_color_s[0]);
  assign fb_write  = pix_avail_s && visible_s;
  assign advance_s = pix_avail_s && (!visible_s || fb_ready);
  assign pop_s     = advance_s && (state_r == ST_DRAW);
  assign fb_x      = dest_x_s[XW-1:0];
  assign fb_y      = dest_y_s[YW-1:0];
  assign fb_color  = pix_color_s;

  // Returns with no read still awaiting data are stale and dropped
  assign push_s = mem_valid && (state_r == ST_DRAW) && (out_cnt_r != fifo_cnt_r);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !zero_s && (cmd_op == OP_DRAW)) begin
          state_nxt_s = ST_DRAW;
        end else if (accept_s && !zero_s && ((cmd_op == OP_FILL) || (cmd_op == OP_CLEAR))) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAW, ST_FILL: begin
        if (advance_s && out_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Command field capture on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= 32'd0;
      src_x_r <= 16'd0;
      src_y_r <= 16'd0;
      pitch_r <= 16'd0;
      w_r     <= 16'd0;
      h_r     <= 16'd0;
      x_r     <= 16'd0;
      y_r     <= 16'd0;
      color_r <= 16'd0;
`ifdef GPU_BLIT_FLIP_EN
      flip_r  <= 2'b00;
`endif
    end else if (accept_s) begin
      addr_r  <= cmd_address;
      src_x_r <= cmd_src_x;
      src_y_r <= cmd_src_y;
      pitch_r <= cmd_image_width;
      color_r <= cmd_color;
`ifdef GPU_BLIT_FLIP_EN
      flip_r  <= cmd_flip;
`endif
      if (cmd_op == OP_CLEAR) begin
        x_r <= 16'd0;
        y_r <= 16'd0;
        w_r <= 16'(FB_WIDTH);
        h_r <= 16'(FB_HEIGHT);
      end else begin
        x_r <= cmd_x;
        y_r <= cmd_y;
        w_r <= cmd_width;
        h_r <= cmd_height;
      end
    end
  end

  // Request raster counter, advances on each accepted read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcol_r     <= 16'd0;
      rrow_r     <= 16'd0;
      req_done_r <= 1'b0;
    end else if (accept_s) begin
      rcol_r     <= 16'd0;
      rrow_r     <= 16'd0;
      req_done_r <= 1'b0;
    end else if (req_fire_s) begin
      if (req_last_s) begin
        req_done_r <= 1'b1;
      end
      if (rcol_r == (w_r - 16'd1)) begin
        rcol_r <= 16'd0;
        rrow_r <= rrow_r + 16'd1;
      end else begin
        rcol_r <= rcol_r + 16'd1;
      end
    end
  end

  // Output raster counter, advances on each written or skipped pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocol_r <= 16'd0;
      orow_r <= 16'd0;
    end else if (accept_s) begin
      ocol_r <= 16'd0;
      orow_r <= 16'd0;
    end else if (advance_s) begin
      if (ocol_r == (w_r - 16'd1)) begin
        ocol_r <= 16'd0;
        orow_r <= orow_r + 16'd1;
      end else begin
        ocol_r <= ocol_r + 16'd1;
      end
    end
  end

  // In-flight count: reads issued minus pixels popped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cnt_r <= {CW{1'b0}};
    end else if (req_fire_s && !pop_s) begin
      out_cnt_r <= out_cnt_r + CW'(1'b1);
    end else if (!req_fire_s && pop_s) begin
      out_cnt_r <= out_cnt_r - CW'(1'b1);
    end
  end

  // Return FIFO pointers, occupancy and storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 16'd0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= mem_data;
        wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      if (push_s && !pop_s) begin
        fifo_cnt_r <= fifo_cnt_r + CW'(1'b1);
      end else if (!push_s && pop_s) begin
        fifo_cnt_r <= fifo_cnt_r - CW'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_gpu_blitter.sv
// -----------------------------------------------------------------------------
// tb_gpu_blitter
//   Directed bench for gpu_blitter. A behavioural memory returns data a fixed
//   number of cycles after each accepted read; the data word for address a is
//   {a[14:0],1'b1} (opaque) unless a equals trans_addr, which returns 16'h0002
//   (transparent). Accepted reads and framebuffer writes are logged into
//   queues on the falling edge and compared against hand-computed tables.
//   The framebuffer is shrunk to 64x48 so a full CLEAR stays short.
// -----------------------------------------------------------------------------
module tb_gpu_blitter;

  localparam int FBW = 64;
  localparam int FBH = 48;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_address;
  logic [15:0] cmd_src_x, cmd_src_y, cmd_image_width, cmd_width, cmd_height;
  logic [15:0] cmd_x, cmd_y, cmd_color;
  logic [1:0]  cmd_flip;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        fb_write;
  logic [6:0]  fb_x;
  logic [6:0]  fb_y;
  logic [15:0] fb_color;
  logic        fb_ready;
  logic        busy;

  gpu_blitter #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_address(cmd_address), .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y),
    .cmd_image_width(cmd_image_width), .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_flip(cmd_flip),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .fb_write(fb_write), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .fb_ready(fb_ready), .busy(busy)
  );

  typedef struct { int due; logic [15:0] data; } ret_t;
  typedef struct { int x; int y; int c; } wr_t;

  ret_t        ret_q[$];
  logic [31:0] rd_q[$];
  wr_t         wr_q[$];

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          mem_lat = 1;
  int          max_out = 0;
  bit          fb_toggle = 1'b0;
  logic [31:0] trans_addr = 32'hFFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source image contents
  function automatic logic [15:0] img(input logic [31:0] a);
    if (a == trans_addr) img = 16'h0002;
    else                 img = {a[14:0], 1'b1};
  endfunction

  // Memory responder and handshake logger, all on the falling edge
  always @(negedge clk) begin : model
    ret_t e;
    wr_t  w;
    if (fb_toggle) fb_ready = ~fb_ready;
    else           fb_ready = 1'b1;
    mem_valid = 1'b0;
    mem_data  = 16'h0000;
    if (ret_q.size() > 0 && ret_q[0].due == cyc + 1) begin
      mem_valid = 1'b1;
      mem_data  = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    if (reset && mem_read && mem_ready) begin
      rd_q.push_back(mem_addr);
      e.due  = cyc + 1 + mem_lat;
      e.data = img(mem_addr);
      ret_q.push_back(e);
    end
    if (reset && fb_write && fb_ready) begin
      w.x = int'(fb_x);
      w.y = int'(fb_y);
      w.c = int'(fb_color);
      wr_q.push_back(w);
    end
    if (rd_q.size() - wr_q.size() > max_out) max_out = rd_q.size() - wr_q.size();
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    max_out = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                          input logic [15:0] sx, input logic [15:0] sy,
                          input logic [15:0] pitch, input logic [15:0] w,
                          input logic [15:0] h, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] color,
                          input logic [1:0] flip);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_address = addr;
    cmd_src_x = sx; cmd_src_y = sy; cmd_image_width = pitch;
    cmd_width = w; cmd_height = h; cmd_x = x; cmd_y = y;
    cmd_color = color; cmd_flip = flip;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rd(input string tag, input int i, input logic [31:0] exp);
    if (i < rd_q.size()) check_val($sformatf("%s_addr%0d", tag, i), rd_q[i], exp);
    else                 check_val($sformatf("%s_addr%0d_missing", tag, i), 32'd0, 32'd1);
  endtask

  task automatic check_wr(input string tag, input int i, input int x, input int y, input int c);
    if (i < wr_q.size()) begin
      check_val($sformatf("%s_x%0d", tag, i), wr_q[i].x, x);
      check_val($sformatf("%s_y%0d", tag, i), wr_q[i].y, y);
      check_val($sformatf("%s_c%0d", tag, i), wr_q[i].c, c);
    end else begin
      check_val($sformatf("%s_wr%0d_missing", tag, i), 32'd0, 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a033 [8];
    int          c033 [8];
    int          nbad_c;
    int          nbad_p;
    a033 = '{32'h1009, 32'h100A, 32'h100B, 32'h100C, 32'h1011, 32'h1012, 32'h1013, 32'h1014};
    c033 = '{'h2013, 'h2015, 'h2017, 'h2019, 'h2023, 'h2025, 'h2027, 'h2029};

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_address = 32'd0;
    cmd_src_x = 16'd0; cmd_src_y = 16'd0; cmd_image_width = 16'd0;
    cmd_width = 16'd0; cmd_height = 16'd0; cmd_x = 16'd0; cmd_y = 16'd0;
    cmd_color = 16'd0; cmd_flip = 2'b00; mem_ready = 1'b1;
    mem_valid = 1'b0; mem_data = 16'd0; fb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_val("rst_fb_write", {31'd0, fb_write}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);

    // DRAW 4x2 from (1,1), pitch 8, to (10,20)
    clear_logs(); mem_lat = 1;
    send_cmd(2'b01, 32'h1000, 16'd1, 16'd1, 16'd8, 16'd4, 16'd2, 16'd10, 16'd20, 16'd0, 2'b00);
    check_val("d1_busy", {31'd0, busy}, 32'd1);
    check_val("d1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check_val("d1_first_read", {31'd0, mem_read}, 32'd1);
    check_val("d1_first_addr", mem_addr, 32'h1009);
    wait_idle(200);
    check_val("d1_nreads", rd_q.size(), 32'd8);
    check_val("d1_nwrites", wr_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check_rd("d1", i, a033[i]);
    for (int i = 0; i < 8; i++) check_wr("d1", i, 10 + (i % 4), 20 + (i / 4), c033[i]);
    check_val("d1_ready_after", {31'd0, cmd_ready}, 32'd1);

    // DRAW 4x1 at x=-2: left two pixels clipped
    clear_logs();
    send_cmd(2'b01, 32'h2000, 16'd0, 16'd0, 16'd16, 16'd4, 16'd1, 16'hFFFE, 16'd5, 16'd0, 2'b00);
    wait_idle(200);
    check_val("d2_nreads", rd_q.size(), 32'd4);
    check_rd("d2", 3, 32'h2003);
    check_val("d2_nwrites", wr_q.size(), 32'd2);
    check_wr("d2", 0, 0, 5, 'h4005);
    check_wr("d2", 1, 1, 5, 'h4007);

    // DRAW 8x1, latency 6, fb_ready toggling
    clear_logs(); mem_lat = 6; fb_toggle = 1'b1;
    send_cmd(2'b01, 32'h3000, 16'd0, 16'd0, 16'd8, 16'd8, 16'd1, 16'd0, 16'd0, 16'd0, 2'b00);
    wait_idle(400);
    fb_toggle = 1'b0; mem_lat = 1;
    check_val("d3_max_outstanding", max_out, 32'd4);
    check_val("d3_nwrites", wr_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check_wr("d3", i, i, 0, 'h6001 + 2 * i);

    // FILL 3x2 at (62,47): only two pixels land; transparency bit ignored
    clear_logs();
    send_cmd(2'b10, 32'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd2, 16'd62, 16'd47, 16'h1234, 2'b00);
    wait_idle(100);
    check_val("f1_nreads", rd_q.size(), 32'd0);
    check_val("f1_nwrites", wr_q.size(), 32'd2);
    check_wr("f1", 0, 62, 47, 'h1234);
    check_wr("f1", 1, 63, 47, 'h1234);

    // Zero-width DRAW and NOP: idle right away, no traffic
    clear_logs();
    send_cmd(2'b01, 32'h5000, 16'd0, 16'd0, 16'd8, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 2'b00);
    check_val("z_busy", {31'd0, busy}, 32'd0);
    send_cmd(2'b00, 32'h5000, 16'd0, 16'd0, 16'd8, 16'd4, 16'd4, 16'd0, 16'd0, 16'd0, 2'b00);
    check_val("nop_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check_val("z_traffic", rd_q.size() + wr_q.size(), 32'd0);

    // DRAW 4x1 from address 0 with flip=01, word at address 1 transparent
    clear_logs(); trans_addr = 32'd1;
    send_cmd(2'b01, 32'd0, 16'd0, 16'd0, 16'd4, 16'd4, 16'd1, 16'd0, 16'd0, 16'd0, 2'b01);
    wait_idle(200);
    trans_addr = 32'hFFFF_FFFF;
    check_val("fl_nwrites", wr_q.size(), 32'd3);
`ifdef GPU_BLIT_FLIP_EN
    check_rd("fl", 0, 32'd3);
    check_rd("fl", 3, 32'd0);
    check_wr("fl", 0, 0, 0, 'h0007);
    check_wr("fl", 1, 1, 0, 'h0005);
    check_wr("fl", 2, 3, 0, 'h0001);
`else
    check_rd("fl", 0, 32'd0);
    check_rd("fl", 3, 32'd3);
    check_wr("fl", 0, 0, 0, 'h0001);
    check_wr("fl", 1, 2, 0, 'h0005);
    check_wr("fl", 2, 3, 0, 'h0007);
`endif

    // CLEAR with colour 0: every framebuffer pixel once, in raster order
    clear_logs();
    send_cmd(2'b11, 32'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd5, 16'd5, 16'h0000, 2'b00);
    wait_idle(FBW * FBH + 100);
    check_val("clr_nwrites", wr_q.size(), FBW * FBH);
    nbad_c = 0; nbad_p = 0;
    foreach (wr_q[i]) begin
      if (wr_q[i].c != 0) nbad_c++;
      if (wr_q[i].x != (i % FBW) || wr_q[i].y != (i / FBW)) nbad_p++;
    end
    check_val("clr_colour_errs", nbad_c, 32'd0);
    check_val("clr_pos_errs", nbad_p, 32'd0);
    check_val("clr_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a DRAW, then a clean FILL 2x2
    clear_logs(); mem_lat = 3;
    send_cmd(2'b01, 32'h4000, 16'd0, 16'd0, 16'd16, 16'd16, 16'd1, 16'd0, 16'd0, 16'd0, 2'b00);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("ab_mem_read", {31'd0, mem_read}, 32'd0);
    check_val("ab_fb_write", {31'd0, fb_write}, 32'd0);
    check_val("ab_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    send_cmd(2'b10, 32'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd2, 16'd0, 16'd0, 16'h0F0F, 2'b00);
    wait_idle(100);
    repeat (6) @(negedge clk);
    check_val("ab_nreads", rd_q.size(), 32'd0);
    check_val("ab_nwrites", wr_q.size(), 32'd4);
    check_wr("ab", 0, 0, 0, 'h0F0F);
    check_wr("ab", 3, 1, 1, 'h0F0F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
